// File: rtl/mc_cpu_ctrl.sv
// mc_cpu_ctrl: multi-cycle MIPS-subset control FSM with retired-instruction counter; MC_CTRL_WAIT_EN adds memory wait states
module mc_cpu_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_wr_cond,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                         S_WB_R = 4'd4, S_EXEC_I = 4'd5, S_WB_I = 4'd6, S_MEM_ADDR = 4'd7,
                         S_MEM_RD = 4'd8, S_WB_LD = 4'd9, S_MEM_WR = 4'd10, S_BRANCH = 4'd11,
                         S_JUMP = 4'd12;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000,
                         ALU_OR = 4'b0001, ALU_SLT = 4'b0111;
  logic [3:0] state, nxt;
  logic [3:0] r_alu;
  logic       r_ok, ready, term;
  logic       unused_zero;
  assign unused_zero = zero;
`ifdef MC_CTRL_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_ready;
  assign unused_ready = mem_ready;
  assign ready = 1'b1;
`endif
  always_comb begin
    r_ok  = 1'b1;
    r_alu = funct == 6'b100000 ? ALU_ADD :
            funct == 6'b100010 ? ALU_SUB :
            funct == 6'b100100 ? ALU_AND :
            funct == 6'b100101 ? ALU_OR  :
            funct == 6'b101010 ? ALU_SLT : ALU_AND;
    if (!(funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})) r_ok = 1'b0;
  end
  always_comb begin
    nxt = S_RST;
    case (state)
      S_RST:      nxt = S_FETCH;
      S_FETCH:    nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = opcode == OP_R    ? (r_ok ? S_EXEC_R : S_FETCH) :
                        opcode == OP_ADDI ? S_EXEC_I :
                        (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                        opcode == OP_BEQ  ? S_BRANCH :
                        opcode == OP_J    ? S_JUMP : S_FETCH;
      S_EXEC_R:   nxt = S_WB_R;
      S_EXEC_I:   nxt = S_WB_I;
      S_MEM_ADDR: nxt = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = ready ? S_WB_LD : S_MEM_RD;
      S_MEM_WR:   nxt = ready ? S_FETCH : S_MEM_WR;
      S_WB_R, S_WB_I, S_WB_LD, S_BRANCH, S_JUMP: nxt = S_FETCH;
      default:    nxt = S_RST;
    endcase
  end
  // a terminal state retires on the edge that leaves it (MEM_WR may be held)
  assign term = (state inside {S_WB_R, S_WB_I, S_WB_LD, S_MEM_WR, S_BRANCH, S_JUMP}) && nxt == S_FETCH;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_RST;
      instr_cnt <= '0;
    end else begin
      state     <= nxt;
      instr_cnt <= instr_cnt + CNT_W'(term);
    end
  end
  assign pc_write   = (state == S_FETCH && ready) || state == S_JUMP;
  assign ir_write   = state == S_FETCH && ready;
  assign pc_wr_cond = state == S_BRANCH;
  assign pc_src     = state == S_BRANCH ? 2'd1 : state == S_JUMP ? 2'd2 : 2'd0;
  assign iord       = state == S_MEM_RD || state == S_MEM_WR;
  assign mem_read   = state == S_FETCH || state == S_MEM_RD;
  assign mem_write  = state == S_MEM_WR;
  assign reg_dst    = state == S_WB_R;
  assign mem_to_reg = state == S_WB_LD;
  assign reg_write  = state == S_WB_R || state == S_WB_I || state == S_WB_LD;
  assign alu_src_a  = state inside {S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_BRANCH};
  assign alu_src_b  = state == S_FETCH ? 2'd1 : state == S_DECODE ? 2'd3 :
                      (state == S_EXEC_I || state == S_MEM_ADDR) ? 2'd2 : 2'd0;
  assign alu_ctrl   = state == S_EXEC_R ? r_alu : state == S_BRANCH ? ALU_SUB :
                      (state inside {S_FETCH, S_DECODE, S_EXEC_I, S_MEM_ADDR}) ? ALU_ADD : 4'b0000;
  assign illegal    = state == S_DECODE && nxt == S_FETCH;
endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// tb_mc_cpu_ctrl: directed checks of mc_cpu_ctrl state sequencing, strobes and a 3-bit wrapping counter
`timescale 1ns/1ps
module tb_mc_cpu_ctrl;
  localparam int CW = 3;
  logic clock = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic pc_write, pc_wr_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_ctrl;
  logic [CW-1:0] instr_cnt;
  logic [18:0] outs;
  int checks = 0, errors = 0, exp_cnt = 0;
  mc_cpu_ctrl #(.CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_wr_cond(pc_wr_cond), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );
  always #5 clock = ~clock;
  assign outs = {pc_write, pc_wr_cond, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, illegal};
  // field order: pw pwc pc_src iord mr mw irw rd m2r rw sa sb alu ill
  localparam logic [18:0] E_FETCH = {1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b0};
  localparam logic [18:0] E_FWAIT = {1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b0};
  localparam logic [18:0] E_DEC   = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0010, 1'b0};
  localparam logic [18:0] E_ILL   = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0010, 1'b1};
  localparam logic [18:0] E_WBR   = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
  localparam logic [18:0] E_EXI   = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010, 1'b0};
  localparam logic [18:0] E_WBI   = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
  localparam logic [18:0] E_MRD   = {1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
  localparam logic [18:0] E_WBLD  = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
  localparam logic [18:0] E_MWR   = {1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
  localparam logic [18:0] E_BR    = {1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0110, 1'b0};
  localparam logic [18:0] E_J     = {1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
  function automatic logic [18:0] e_exr(input logic [3:0] ac);
    return {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, ac, 1'b0};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [18:0] e);
    @(negedge clock);
    chk(tag, 32'(outs), 32'(e));
  endtask
  task automatic cnt(input string tag);
    chk(tag, 32'(instr_cnt), 32'(exp_cnt % (1 << CW)));
  endtask
  task automatic r_instr(input string tag, input logic [5:0] f, input logic [3:0] ac);
    opcode = 6'b000000; funct = f;
    step({tag, "_dec"}, E_DEC);
    step({tag, "_exec"}, e_exr(ac));
    step({tag, "_wb"}, E_WBR);
    step({tag, "_fetch"}, E_FETCH);
    exp_cnt++;
    cnt({tag, "_cnt"});
  endtask
  initial begin
    #1 reset = 1'b0;
    #3 chk("rst_outs", 32'(outs), 32'd0);
    cnt("rst_cnt");
    @(negedge clock) reset = 1'b1;
    step("fetch0", E_FETCH);
    cnt("cnt0");
    r_instr("sub", 6'b100010, 4'b0110);
    opcode = 6'b100011;
    step("lw_dec", E_DEC);
    step("lw_addr", E_EXI);
    step("lw_mrd", E_MRD);
    step("lw_wb", E_WBLD);
    step("lw_fetch", E_FETCH);
    exp_cnt++; cnt("lw_cnt");
    opcode = 6'b000100; zero = 1'b1;
    step("beq1_dec", E_DEC);
    step("beq1_br", E_BR);
    step("beq1_fetch", E_FETCH);
    exp_cnt++; cnt("beq1_cnt");
    zero = 1'b0;
    step("beq0_dec", E_DEC);
    step("beq0_br", E_BR);
    step("beq0_fetch", E_FETCH);
    exp_cnt++; cnt("beq0_cnt");
    opcode = 6'b111111;
    step("ill_op_dec", E_ILL);
    step("ill_op_fetch", E_FETCH);
    cnt("ill_op_cnt");
    opcode = 6'b000000; funct = 6'b000000;
    step("ill_fn_dec", E_ILL);
    step("ill_fn_fetch", E_FETCH);
    cnt("ill_fn_cnt");
    opcode = 6'b001000;
    step("addi_dec", E_DEC);
    step("addi_exec", E_EXI);
    step("addi_wb", E_WBI);
    step("addi_fetch", E_FETCH);
    exp_cnt++; cnt("addi_cnt");
    opcode = 6'b101011;
    step("sw_dec", E_DEC);
    step("sw_addr", E_EXI);
    step("sw_mwr", E_MWR);
    step("sw_fetch", E_FETCH);
    exp_cnt++; cnt("sw_cnt");
    opcode = 6'b000010;
    step("j_dec", E_DEC);
    step("j_jump", E_J);
    step("j_fetch", E_FETCH);
    exp_cnt++; cnt("j_cnt");
    r_instr("and", 6'b100100, 4'b0000);
    chk("wrap_to_zero", 32'(instr_cnt), 32'd0);
    r_instr("or", 6'b100101, 4'b0001);
    r_instr("slt", 6'b101010, 4'b0111);
    r_instr("add", 6'b100000, 4'b0010);
    opcode = 6'b000000; funct = 6'b100010;
    step("rr_dec", E_DEC);
    step("rr_exec", e_exr(4'b0110));
    step("rr_wb", E_WBR);
    #2 reset = 1'b0;
    #1 chk("rr_regwrite", 32'(reg_write), 32'd0);
    chk("rr_outs", 32'(outs), 32'd0);
    exp_cnt = 0;
    cnt("rr_cnt");
    @(negedge clock) reset = 1'b1;
    step("rr_fetch", E_FETCH);
    r_instr("post_rst", 6'b100010, 4'b0110);
`ifdef MC_CTRL_WAIT_EN
    opcode = 6'b101011;
    step("wsw_dec", E_DEC);
    step("wsw_addr", E_EXI);
    mem_ready = 1'b0;
    step("wsw_mwr1", E_MWR);
    step("wsw_mwr2", E_MWR);
    step("wsw_mwr3", E_MWR);
    mem_ready = 1'b1;
    #1 chk("wsw_mwr4", 32'(outs), 32'(E_MWR));
    mem_ready = 1'b0;
    step("wf_hold1", E_FWAIT);
    exp_cnt++; cnt("wsw_cnt");
    step("wf_hold2", E_FWAIT);
    mem_ready = 1'b1;
    #1 chk("wf_go", 32'(outs), 32'(E_FETCH));
    step("wf_dec", E_DEC);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
